line_writer: RTL and testbench

//  Write-side counterpart of the display line buffer: gathers one row of pixel words from the

---
 rtl/fractal_mem_pkg.sv | 18 +
 rtl/line_ram_sdp.sv | 41 ++++
 rtl/line_writer.sv | 176 +++++++++++++++++
 tb/tb_line_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_mem_pkg.sv
// Shared types and helpers for the fractal frame-buffer memory path.
// The state encoding is used by the line writer FSM.
package fractal_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        LOAD    = 2'd2,
        WRITING = 2'd3
    } state_t;

    localparam state_t RESET_STATE = IDLE;

    function automatic int interface_width_bytes(input int width_bits);
        return width_bits / 8;
    endfunction

endpackage

// File: rtl/line_ram_sdp.sv
// Simple dual-port line RAM: one write port and one registered, enabled read port.
// The read register holds its value between enables and therefore doubles as the output data register.
module line_ram_sdp #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 write_enable,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [WIDTH-1:0]     write_data,
    input  logic                 read_enable,
    input  logic [ADDR_BITS-1:0] read_address,
    output logic [WIDTH-1:0]     read_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] read_data_r;

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem_r[write_address] <= write_data;
        end
    end

    // Registered read port; keeps the last word while read_enable is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data_r <= {WIDTH{1'b0}};
        end else if (read_enable) begin
            read_data_r <= mem_r[read_address];
        end else begin
            read_data_r <= read_data_r;
        end
    end

    assign read_data = read_data_r;

endmodule

// File: rtl/line_writer.sv
// Collects one row of pixel words from the fractal engine into a line RAM and
// writes it to the frame buffer through the bridge as single-word master writes.
module line_writer
    import fractal_mem_pkg::*;
#(
    parameter int INTERFACE_WIDTH_BITS = 128,
    parameter int NUM_BUFFER_ENTRIES   = 64,
    parameter int INTERFACE_ADDR_BITS  = 26
) (
    input  logic                                interface_clock,
    input  logic                                reset_n,
    output logic [INTERFACE_ADDR_BITS-1:0]      interface_address,
    output logic [INTERFACE_WIDTH_BITS/8-1:0]   interface_byte_enable,
    output logic                                interface_read,
    output logic                                interface_write,
    input  logic [INTERFACE_WIDTH_BITS-1:0]     interface_read_data,
    output logic [INTERFACE_WIDTH_BITS-1:0]     interface_write_data,
    input  logic                                interface_acknowledge,
    input  logic                                start,
    input  logic [INTERFACE_ADDR_BITS-1:0]      base_address,
    input  logic [INTERFACE_WIDTH_BITS-1:0]     pixel_data,
    input  logic                                pixel_valid,
    output logic                                pixel_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                timing_error,
    input  logic                                timing_error_reset
);

    localparam int IWB   = INTERFACE_WIDTH_BITS;
    localparam int IAB   = INTERFACE_ADDR_BITS;
    localparam int BYTES = interface_width_bytes(IWB);
    localparam int AW    = $clog2(NUM_BUFFER_ENTRIES);
    localparam int SH    = $clog2(BYTES);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BUFFER_ENTRIES - 1);
    localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

    state_t          state_r;
    logic            start_last_r;
    logic            armed_r;
    logic [IAB-1:0]  base_r;
    logic [AW-1:0]   fill_addr_r;
    logic [AW-1:0]   drain_addr_r;
    logic [IAB-1:0]  address_r;
    logic            write_r;
    logic            ready_r;
    logic            busy_r;
    logic            done_r;
    logic            timing_error_r;

    logic            start_rise_s;
    logic            accept_s;
    logic            ram_read_s;
    logic            ack_s;
    logic [IAB-1:0]  drain_offset_s;
    logic            unused_read_data_s;

    // armed_r masks the first cycle after reset so a start held high through reset is not an edge.
    assign start_rise_s       = start & ~start_last_r & armed_r;
    assign accept_s           = (state_r == FILLING) & pixel_valid;
    assign ram_read_s         = (state_r == LOAD);
    assign ack_s              = (state_r == WRITING) & interface_acknowledge;
    assign drain_offset_s     = {{(IAB-AW){1'b0}}, drain_addr_r} << SH;
    assign unused_read_data_s = ^interface_read_data;

    line_ram_sdp #(
        .WIDTH     (IWB),
        .DEPTH     (NUM_BUFFER_ENTRIES),
        .ADDR_BITS (AW)
    ) u_line_ram (
        .clock         (interface_clock),
        .reset_n       (reset_n),
        .write_enable  (accept_s),
        .write_address (fill_addr_r),
        .write_data    (pixel_data),
        .read_enable   (ram_read_s),
        .read_address  (drain_addr_r),
        .read_data     (interface_write_data)
    );

    // Start edge detector history and post-reset arming.
    always_ff @(posedge interface_clock or negedge reset_n) begin
        if (!reset_n) begin
            start_last_r <= 1'b0;
            armed_r      <= 1'b0;
        end else begin
            start_last_r <= start;
            armed_r      <= 1'b1;
        end
    end

    // Sticky timing error; a new violation wins over a clear in the same cycle.
    always_ff @(posedge interface_clock or negedge reset_n) begin
        if (!reset_n) begin
            timing_error_r <= 1'b0;
        end else if (start_rise_s && (state_r != IDLE)) begin
            timing_error_r <= 1'b1;
        end else if (timing_error_reset) begin
            timing_error_r <= 1'b0;
        end else begin
            timing_error_r <= timing_error_r;
        end
    end

    // Row FSM with registered handshake and status outputs.
    always_ff @(posedge interface_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= RESET_STATE;
            base_r       <= {IAB{1'b0}};
            fill_addr_r  <= {AW{1'b0}};
            drain_addr_r <= {AW{1'b0}};
            address_r    <= {IAB{1'b0}};
            write_r      <= 1'b0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_rise_s) begin
                        base_r      <= base_address;
                        fill_addr_r <= {AW{1'b0}};
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= FILLING;
                    end
                end
                FILLING: begin
                    if (pixel_valid) begin
                        fill_addr_r <= fill_addr_r + ONE_ADDR;
                        if (fill_addr_r == LAST_ADDR) begin
                            drain_addr_r <= {AW{1'b0}};
                            ready_r      <= 1'b0;
                            state_r      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    address_r <= base_r + drain_offset_s;
                    write_r   <= 1'b1;
                    state_r   <= WRITING;
                end
                WRITING: begin
                    if (ack_s) begin
                        write_r <= 1'b0;
                        if (drain_addr_r == LAST_ADDR) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            drain_addr_r <= drain_addr_r + ONE_ADDR;
                            state_r      <= LOAD;
                        end
                    end
                end
                default: begin
                    write_r <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign interface_address     = address_r;
    assign interface_byte_enable = {(IWB/8){1'b1}};
    assign interface_read        = 1'b0;
    assign interface_write       = write_r;
    assign pixel_ready           = ready_r;
    assign busy                  = busy_r;
    assign done                  = done_r;
    assign timing_error          = timing_error_r;

endmodule

// File: tb/tb_line_writer.sv
// Randomized bench for line_writer (N=4, 128-bit words): a reference model built from
// pixel queues and address arithmetic predicts every bridge write of each row.
module tb_line_writer;

    localparam int IWB = 128;
    localparam int N   = 4;
    localparam int IAB = 26;

    logic             interface_clock = 1'b0;
    logic             reset_n;
    logic [IAB-1:0]   interface_address;
    logic [IWB/8-1:0] interface_byte_enable;
    logic             interface_read;
    logic             interface_write;
    logic [IWB-1:0]   interface_read_data;
    logic [IWB-1:0]   interface_write_data;
    logic             interface_acknowledge;
    logic             start;
    logic [IAB-1:0]   base_address;
    logic [IWB-1:0]   pixel_data;
    logic             pixel_valid;
    logic             pixel_ready;
    logic             busy;
    logic             done;
    logic             timing_error;
    logic             timing_error_reset;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [IAB-1:0] obs_addr [$];
    logic [IWB-1:0] obs_data [$];
    int             done_cnt   = 0;
    int             ack_wcnt   = 0;
    int             cur_delay  = 0;
    int             stall_word = -1;
    int             stall_len  = 0;
    logic [IAB-1:0] cap_addr;
    logic [IWB-1:0] cap_data;

    line_writer #(
        .INTERFACE_WIDTH_BITS (IWB),
        .NUM_BUFFER_ENTRIES   (N),
        .INTERFACE_ADDR_BITS  (IAB)
    ) dut (
        .interface_clock       (interface_clock),
        .reset_n               (reset_n),
        .interface_address     (interface_address),
        .interface_byte_enable (interface_byte_enable),
        .interface_read        (interface_read),
        .interface_write       (interface_write),
        .interface_read_data   (interface_read_data),
        .interface_write_data  (interface_write_data),
        .interface_acknowledge (interface_acknowledge),
        .start                 (start),
        .base_address          (base_address),
        .pixel_data            (pixel_data),
        .pixel_valid           (pixel_valid),
        .pixel_ready           (pixel_ready),
        .busy                  (busy),
        .done                  (done),
        .timing_error          (timing_error),
        .timing_error_reset    (timing_error_reset)
    );

    always #5 interface_clock = ~interface_clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bridge model: random acknowledge latency, spurious acks while idle, records accepted writes.
    always @(negedge interface_clock) begin
        if (!reset_n) begin
            interface_acknowledge = 1'b0;
            ack_wcnt = 0;
        end else if (interface_acknowledge) begin
            interface_acknowledge = 1'b0;
            ack_wcnt = 0;
        end else if (interface_write) begin
            if (ack_wcnt == 0) begin
                cap_addr  = interface_address;
                cap_data  = interface_write_data;
                cur_delay = (obs_addr.size() == stall_word) ? stall_len : int'($urandom_range(0, 2));
            end else begin
                check_eq("addr_stable", 128'(interface_address), 128'(cap_addr));
                check_eq("data_stable", interface_write_data, cap_data);
            end
            if (ack_wcnt >= cur_delay) begin
                interface_acknowledge = 1'b1;
                obs_addr.push_back(cap_addr);
                obs_data.push_back(cap_data);
            end
            ack_wcnt++;
        end else if ($urandom_range(0, 3) == 0) begin
            interface_acknowledge = 1'b1;
        end
    end

    // done must be a lone pulse with the block already idle and no write pending.
    always @(negedge interface_clock) begin
        if (reset_n && done) begin
            done_cnt++;
            check_eq("done_busy", 128'(busy), 128'(1'b0));
            check_eq("done_write", 128'(interface_write), 128'(1'b0));
        end
    end

    // gap_mode: 0 back-to-back, 1 toggling, 2 random. inject: 0 none, 1 start edge in WRITING,
    // 2 additionally a later start edge coincident with timing_error_reset.
    task automatic run_row(input logic [IAB-1:0] base, input int gap_mode, input int stall_idx,
                           input int inject, input logic exp_terr);
        logic [IWB-1:0] pix [N];
        logic [IAB-1:0] exp_a;
        int idx;
        int cyc;
        int step;
        idx  = 0;
        cyc  = 0;
        step = 0;
        for (int i = 0; i < N; i++) pix[i] = {$urandom, $urandom, $urandom, $urandom};
        obs_addr.delete();
        obs_data.delete();
        done_cnt   = 0;
        stall_word = stall_idx;
        stall_len  = 5;
        @(negedge interface_clock);
        base_address = base;
        start = 1'b1;
        @(negedge interface_clock);
        start = 1'b0;
        check_eq("busy_after_start", 128'(busy), 128'(1'b1));
        check_eq("ready_after_start", 128'(pixel_ready), 128'(1'b1));
        while (idx < N && cyc < 200) begin
            @(negedge interface_clock);
            cyc++;
            case (gap_mode)
                0:       pixel_valid = 1'b1;
                1:       pixel_valid = cyc[0];
                default: pixel_valid = 1'($urandom_range(0, 1));
            endcase
            pixel_data = pix[idx];
            if (pixel_ready && pixel_valid) idx++;
        end
        if (idx < N) check_eq("fill_timeout", 128'(idx), 128'(N));
        cyc = 0;
        while (cyc < 400) begin
            @(negedge interface_clock);
            cyc++;
            pixel_valid = 1'b1;
            pixel_data  = {$urandom, $urandom, $urandom, $urandom};
            if (done) break;
            if (start) begin
                start = 1'b0;
                timing_error_reset = 1'b0;
            end else if (inject >= 1 && step == 0 && interface_write) begin
                start = 1'b1;
                step = 1;
            end else if (inject == 2 && step == 1 && interface_write && obs_addr.size() >= 2) begin
                start = 1'b1;
                timing_error_reset = 1'b1;
                step = 2;
            end
        end
        if (cyc >= 400) check_eq("done_timeout", 128'(cyc), 128'(0));
        start = 1'b0;
        timing_error_reset = 1'b0;
        pixel_valid = 1'b0;
        repeat (2) @(negedge interface_clock);
        check_eq("done_count", 128'(done_cnt), 128'(1));
        check_eq("busy_idle", 128'(busy), 128'(1'b0));
        check_eq("write_count", 128'(obs_addr.size()), 128'(N));
        for (int i = 0; i < N && i < obs_addr.size(); i++) begin
            exp_a = base + IAB'(i * (IWB / 8));
            check_eq("write_addr", 128'(obs_addr[i]), 128'(exp_a));
            check_eq("write_data", obs_data[i], pix[i]);
        end
        check_eq("timing_error", 128'(timing_error), 128'(exp_terr));
    endtask

    initial begin
        int cyc;
        reset_n             = 1'b0;
        start               = 1'b0;
        base_address        = '0;
        pixel_data          = '0;
        pixel_valid         = 1'b0;
        timing_error_reset  = 1'b0;
        interface_read_data = '0;
        interface_acknowledge = 1'b0;
        #12;
        check_eq("rst_write", 128'(interface_write), 128'(1'b0));
        check_eq("rst_addr", 128'(interface_address), 128'(0));
        check_eq("rst_data", interface_write_data, 128'(0));
        check_eq("rst_ready", 128'(pixel_ready), 128'(1'b0));
        check_eq("rst_busy", 128'(busy), 128'(1'b0));
        check_eq("rst_done", 128'(done), 128'(1'b0));
        check_eq("rst_terr", 128'(timing_error), 128'(1'b0));
        check_eq("byte_enable", 128'(interface_byte_enable), 128'(16'hFFFF));
        check_eq("read_const", 128'(interface_read), 128'(1'b0));
        @(negedge interface_clock);
        reset_n = 1'b1;
        repeat (2) @(negedge interface_clock);

        run_row(26'h0000100, 0, -1, 0, 1'b0);   // basic row
        run_row(26'h0000100, 0, 2, 0, 1'b0);    // long ack stall on third word
        run_row(26'h0000100, 1, -1, 0, 1'b0);   // toggling valid
        run_row(26'h0000100, 0, -1, 1, 1'b1);   // start edge while writing
        @(negedge interface_clock);
        timing_error_reset = 1'b1;
        @(negedge interface_clock);
        timing_error_reset = 1'b0;
        check_eq("terr_cleared", 128'(timing_error), 128'(1'b0));
        run_row(26'h0000100, 2, -1, 2, 1'b1);   // set beats simultaneous clear
        @(negedge interface_clock);
        timing_error_reset = 1'b1;
        @(negedge interface_clock);
        timing_error_reset = 1'b0;
        run_row(26'h3FFFFF0, 0, -1, 0, 1'b0);   // address wrap
        for (int r = 0; r < 5; r++) begin
            run_row(IAB'({$urandom}), 2, int'($urandom_range(0, N - 1)), 0, 1'b0);
        end

        // Asynchronous reset in the middle of the write phase.
        @(negedge interface_clock);
        base_address = 26'h0000100;
        start = 1'b1;
        @(negedge interface_clock);
        pixel_valid = 1'b1;
        cyc = 0;
        while (!interface_write && cyc < 100) begin
            @(negedge interface_clock);
            cyc++;
        end
        check_eq("reach_writing", 128'(interface_write), 128'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_write", 128'(interface_write), 128'(1'b0));
        check_eq("arst_busy", 128'(busy), 128'(1'b0));
        check_eq("arst_addr", 128'(interface_address), 128'(0));
        pixel_valid = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        @(negedge interface_clock);
        reset_n = 1'b1;
        repeat (8) @(negedge interface_clock);
        check_eq("post_rst_writes", 128'(obs_addr.size()), 128'(0));
        check_eq("post_rst_busy", 128'(busy), 128'(1'b0));
        check_eq("post_rst_ready", 128'(pixel_ready), 128'(1'b0));
        start = 1'b0;
        run_row(26'h0000200, 2, -1, 0, 1'b0);   // recovery after reset

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
